rv_deserializer: RTL and testbench
==================================

# rv_deserializer

Serial-to-parallel receiver, the receive-side counterpart of the MSB-first shift-out path built from `rv_shift_register`. It accepts one bit per qualified strobe, aligns word boundaries to an explicit frame-start marker, and assembles `WIDTH`-bit words. Each word is presented on a valid/ready output port backed by a single holding register. Overruns and mid-word re-alignments are flagged and counted, so upstream serial links (SPI-like, test streams) can be checked for loss.

## Interface
- `WIDTH`, 8: word width in bits; must be ≥ 2.
- `ERR_COUNT_WIDTH`, 8: width of the saturating error counters.

- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `bit_valid`  in  1: `bit_data` is a new serial bit this cycle.
- `bit_data`  in  1: serial bit, MSB of each word first.
- `frame_start`  in  1: qualified by `bit_valid`; this bit is bit 0 (MSB) of a new word.
- `word_valid`  out  1: holding register contains a word.
- `word_ready`  in  1: consumer accepts the word when `word_valid && word_ready`.
- `word_data`  out  WIDTH: assembled word; first received bit is in `[WIDTH-1]`.
- `aligned`  out  1: state is SHIFT.
- `overrun`  out  1: one-cycle pulse when a completed word is dropped.
- `realign`  out  1: one-cycle pulse when `frame_start` discards a partial word.
- `overrun_count`  out  ERR_COUNT_WIDTH: saturating count of overruns.
- `realign_count`  out  ERR_COUNT_WIDTH: saturating count of realigns.

## Operation
- States: ALIGN (reset state) and SHIFT.
- ALIGN: bits without `frame_start` are ignored. `bit_valid && frame_start` loads the bit as bit 0, sets bit index = 1, and moves to SHIFT.
- SHIFT, on `bit_valid` without `frame_start`:
  - The bit shifts into the LSB of the shifter: `shift <= {shift[WIDTH-2:0], bit_data}`.
  - The bit index increments.
- When the index reaches WIDTH-1 and the bit is accepted, the word is complete: `{shift[WIDTH-2:0], bit_data}`. The index wraps to 0 and the block stays in SHIFT, so streaming continues without a new `frame_start`.
- SHIFT, on `bit_valid && frame_start`:
  - If the index ≠ 0, the partial word is discarded, `realign` pulses and `realign_count` increments.
  - The bit becomes bit 0 of a new word and the index becomes 1.
  - If the index = 0, this is a normal boundary with no realign.
  - If the index = WIDTH-1, the old partial is discarded; that bit does not complete a word.
- Holding register, on word completion:
  - Empty, or being consumed this cycle (`word_valid && word_ready`): the word loads and `word_valid` = 1 next cycle.
  - Full and not consumed: the new word is dropped, the held word is unchanged, `overrun` pulses and `overrun_count` increments.
- `word_valid && word_ready` with no completion: `word_valid` clears next cycle.
- Both counters saturate at all-ones and do not wrap.
- `WIDTH` = 1 is unsupported; elaboration fails via a width check.

## Timing
- Reset values: state ALIGN, index 0, `word_valid` 0, `word_data` 0, `aligned` 0, `overrun` 0, `realign` 0, both counts 0.
- Reset mid-word or with a word held: everything returns to reset values next cycle and held data is lost.
- Latency: a word completed by the bit accepted in cycle N has `word_valid` = 1 and `word_data` stable in cycle N+1.
- Throughput: one word per WIDTH accepted bits. Back-to-back words with `word_ready` tied high never overrun.
- `word_data` holds stable while `word_valid && !word_ready`.
- `word_valid` never depends combinationally on `word_ready`.
- `overrun` and `realign` are registered pulses, asserted in cycle N+1 for an event in cycle N.
- `aligned` goes to 1 in the cycle after the first `frame_start`.
- `frame_start` without `bit_valid` is ignored.

## Structure
- The shared package `rv_misc_pkg` holds the `rv_deserializer_state_t` enum (`RV_DESER_ALIGN`, `RV_DESER_SHIFT`).
- Index width is `$clog2(WIDTH)`, computed locally.
- The bit index is an instance of `rv_counter`:
  - `enable = bit_valid` in SHIFT.
  - `load_enable` on `frame_start`, with `load_value` 1.
  - `max = WIDTH-1`.
  - `complete` drives word completion.
- The shifter, holding register, error pulses and counters are local registers.

## Test plan
- All tests use WIDTH=8. Single word: `frame_start` with the first bit, then bits 1,0,1,0,0,1,0,1 on consecutive cycles, `word_ready` = 1 → `word_data` = 0xA5, `word_valid` high exactly one cycle, the cycle after the 8th bit.
- Streaming: 0x3C then 0xFF with only the first `frame_start` and `word_ready` = 1 → two words, no overrun or realign.
- Overrun: `word_ready` = 0 and send 0x11 then 0x22 → `word_data` stays 0x11, one `overrun` pulse, `overrun_count` = 1. Raise `word_ready` → 0x11 is consumed and `word_valid` drops.
- Realign: 3 bits, then `frame_start` and 0x5A → `realign` pulses once, output 0x5A, `realign_count` = 1.
- Ignore before align: 20 bits without `frame_start` → `aligned` = 0, no `word_valid`. Saturation: force 300 overruns → `overrun_count` = 255.
- Reset mid-word after 4 bits, or with a word held → all outputs return to reset values. A subsequent framed 0xC3 is received correctly.

Source files
------------

// File: rtl/rv_misc_pkg.sv
// rtl/rv_misc_pkg.sv - shared enums for the rv_* serial helpers
package rv_misc_pkg;

  typedef enum logic {
    RV_DESER_ALIGN = 1'b0,
    RV_DESER_SHIFT = 1'b1
  } rv_deserializer_state_t;

endpackage

// File: rtl/rv_counter.sv
// rtl/rv_counter.sv - loadable wrap-at-max counter with completion strobe
module rv_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load_enable,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count,
  output logic             complete
);

  logic [WIDTH-1:0] r_count;

  // A load overrides counting, so a completion is never reported on a load cycle.
  assign complete = enable && !load_enable && (r_count == max);
  assign count    = r_count;

  // Count register: load has priority, otherwise step and wrap to zero at max.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load_enable) begin
      r_count <= load_value;
    end else if (enable) begin
      r_count <= complete ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/rv_deserializer.sv
// rtl/rv_deserializer.sv - framed MSB-first serial-to-parallel receiver with valid/ready output
module rv_deserializer
  import rv_misc_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int ERR_COUNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_valid,
  input  logic                       bit_data,
  input  logic                       frame_start,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [WIDTH-1:0]           word_data,
  output logic                       aligned,
  output logic                       overrun,
  output logic                       realign,
  output logic [ERR_COUNT_WIDTH-1:0] overrun_count,
  output logic [ERR_COUNT_WIDTH-1:0] realign_count
);

  localparam int IDX_W = $clog2(WIDTH);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("rv_deserializer: WIDTH must be at least 2");
    end
  endgenerate

  rv_deserializer_state_t r_state, w_state_next;

  // Only the low WIDTH-1 bits are kept; the final bit of a word comes straight from bit_data.
  logic [WIDTH-2:0]           r_shift;
  logic [WIDTH-1:0]           r_word;
  logic                       r_valid;
  logic                       r_overrun;
  logic                       r_realign;
  logic [ERR_COUNT_WIDTH-1:0] r_overrun_count;
  logic [ERR_COUNT_WIDTH-1:0] r_realign_count;

  logic             w_frame;
  logic             w_shift_bit;
  logic             w_complete;
  logic             w_realign;
  logic             w_consume;
  logic             w_overrun;
  logic [IDX_W-1:0] w_index;
  logic [WIDTH-1:0] w_word;

  assign w_frame     = bit_valid && frame_start;
  assign w_shift_bit = bit_valid && !frame_start && (r_state == RV_DESER_SHIFT);
  assign w_realign   = w_frame && (r_state == RV_DESER_SHIFT) && (w_index != '0);
  assign w_consume   = r_valid && word_ready;
  assign w_overrun   = w_complete && r_valid && !word_ready;
  assign w_word      = {r_shift, bit_data};

  rv_counter #(
    .WIDTH(IDX_W)
  ) u_index (
    .clk        (clk),
    .rst        (rst),
    .enable     (w_shift_bit),
    .load_enable(w_frame),
    .load_value (IDX_W'(1)),
    .max        (IDX_W'(WIDTH - 1)),
    .count      (w_index),
    .complete   (w_complete)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= RV_DESER_ALIGN;
    else     r_state <= w_state_next;
  end

  // Next state: a framed bit aligns; once aligned the receiver streams indefinitely.
  always_comb begin
    w_state_next = r_state;
    if (w_frame) w_state_next = RV_DESER_SHIFT;
  end

  // Shifter: a framed bit restarts the word, an ordinary bit enters at the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
    end else if (w_frame) begin
      r_shift <= (WIDTH-1)'(bit_data);
    end else if (w_shift_bit) begin
      r_shift <= (WIDTH-1)'({r_shift, bit_data});
    end
  end

  // Holding register: accept a completed word when empty or draining, otherwise drop it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_word  <= '0;
    end else if (w_complete && (!r_valid || word_ready)) begin
      r_valid <= 1'b1;
      r_word  <= w_word;
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end
  end

  // Error pulses and saturating error counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun       <= 1'b0;
      r_realign       <= 1'b0;
      r_overrun_count <= '0;
      r_realign_count <= '0;
    end else begin
      r_overrun <= w_overrun;
      r_realign <= w_realign;
      if (w_overrun && (r_overrun_count != '1)) r_overrun_count <= r_overrun_count + 1'b1;
      if (w_realign && (r_realign_count != '1)) r_realign_count <= r_realign_count + 1'b1;
    end
  end

  assign word_valid    = r_valid;
  assign word_data     = r_word;
  assign aligned       = (r_state == RV_DESER_SHIFT);
  assign overrun       = r_overrun;
  assign realign       = r_realign;
  assign overrun_count = r_overrun_count;
  assign realign_count = r_realign_count;

endmodule

// File: tb/tb_rv_deserializer.sv
// tb/tb_rv_deserializer.sv - directed self-checking bench for rv_deserializer
module tb_rv_deserializer;

  localparam int W  = 8;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_valid;
  logic          bit_data;
  logic          frame_start;
  logic          word_valid;
  logic          word_ready;
  logic [W-1:0]  word_data;
  logic          aligned;
  logic          overrun;
  logic          realign;
  logic [EW-1:0] overrun_count;
  logic [EW-1:0] realign_count;

  int checks = 0;
  int errors = 0;

  rv_deserializer #(
    .WIDTH          (W),
    .ERR_COUNT_WIDTH(EW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bit_valid    (bit_valid),
    .bit_data     (bit_data),
    .frame_start  (frame_start),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word_data    (word_data),
    .aligned      (aligned),
    .overrun      (overrun),
    .realign      (realign),
    .overrun_count(overrun_count),
    .realign_count(realign_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic step(input logic v, input logic d, input logic fs);
    bit_valid   = v;
    bit_data    = d;
    frame_start = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic fs);
    for (int i = 7; i >= 0; i--) step(1'b1, w[i], (i == 7) ? fs : 1'b0);
    bit_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_aligned"}, aligned, 0);
    check({tag, "_valid"},   word_valid, 0);
    check({tag, "_data"},    word_data, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_realign"}, realign, 0);
    check({tag, "_ocount"},  overrun_count, 0);
    check({tag, "_rcount"},  realign_count, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    logic       seen;

    rst         = 1'b1;
    bit_valid   = 1'b0;
    bit_data    = 1'b0;
    frame_start = 1'b0;
    word_ready  = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_reset("por");
    rst = 1'b0;

    // Single framed word 0xA5, consumer always ready.
    word_ready = 1'b1;
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, pat[i], i == 7);
      if (i == 7) check("t1_aligned", aligned, 1);
      if (i == 1) check("t1_valid_early", word_valid, 0);
    end
    bit_valid = 1'b0;
    frame_start = 1'b0;
    check("t1_valid", word_valid, 1);
    check("t1_data", word_data, 8'hA5);
    step(1'b0, 1'b0, 1'b0);
    check("t1_valid_drop", word_valid, 0);

    // Streaming two words on one frame_start.
    send_word(8'h3C, 1'b1);
    check("t2_valid_a", word_valid, 1);
    check("t2_data_a", word_data, 8'h3C);
    send_word(8'hFF, 1'b0);
    check("t2_valid_b", word_valid, 1);
    check("t2_data_b", word_data, 8'hFF);
    check("t2_ocount", overrun_count, 0);
    check("t2_rcount", realign_count, 0);
    step(1'b0, 1'b0, 1'b0);

    // Overrun: second word dropped while the first is held.
    word_ready = 1'b0;
    send_word(8'h11, 1'b1);
    check("t3_valid_a", word_valid, 1);
    check("t3_data_a", word_data, 8'h11);
    check("t3_no_overrun", overrun, 0);
    send_word(8'h22, 1'b0);
    check("t3_overrun", overrun, 1);
    check("t3_data_held", word_data, 8'h11);
    check("t3_ocount", overrun_count, 1);
    check("t3_valid_held", word_valid, 1);
    step(1'b0, 1'b0, 1'b0);
    check("t3_overrun_pulse", overrun, 0);
    check("t3_data_still", word_data, 8'h11);
    word_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("t3_consumed", word_valid, 0);

    // Realign: three stray bits, then framed 0x5A.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    pat = 8'h5A;
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, pat[i], i == 7);
      if (i == 7) check("t4_realign", realign, 1);
      if (i == 6) check("t4_realign_pulse", realign, 0);
    end
    bit_valid = 1'b0;
    frame_start = 1'b0;
    check("t4_valid", word_valid, 1);
    check("t4_data", word_data, 8'h5A);
    check("t4_rcount", realign_count, 1);
    check("t4_ocount", overrun_count, 1);
    step(1'b0, 1'b0, 1'b0);

    // Bits before any frame_start are ignored; frame_start alone is ignored.
    pulse_reset();
    check_reset("rst1");
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'($urandom_range(1)), 1'b0);
      seen = seen | aligned | word_valid;
    end
    step(1'b0, 1'b1, 1'b1);
    seen = seen | aligned | word_valid;
    check("t5_ignored", seen, 0);

    // Saturation: one held word then 300 dropped words.
    word_ready = 1'b0;
    send_word(8'h00, 1'b1);
    for (int n = 0; n < 300; n++) send_word(8'h00, 1'b0);
    check("t5_sat", overrun_count, 255);
    check("t5_sat_valid", word_valid, 1);

    // Reset with a word held and counters nonzero.
    pulse_reset();
    check_reset("rst_held");

    // Reset mid-word after four bits.
    word_ready = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    bit_valid = 1'b0;
    frame_start = 1'b0;
    pulse_reset();
    check_reset("rst_mid");

    // Reset with a freshly held word.
    word_ready = 1'b0;
    send_word(8'h96, 1'b1);
    check("t6_held", word_valid, 1);
    pulse_reset();
    check_reset("rst_held2");

    // Clean reception after reset.
    word_ready = 1'b1;
    send_word(8'hC3, 1'b1);
    check("t6_valid", word_valid, 1);
    check("t6_data", word_data, 8'hC3);
    check("t6_rcount", realign_count, 0);
    step(1'b0, 1'b0, 1'b0);
    check("t6_drop", word_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
